// File: rtl/aes_pkg.sv
// Shared AES datapath types and constants for the output stage.
// Also provides the word-select helper used by the serializer.
package aes_pkg;

  localparam int AES_BLOCK_W         = 128;
  localparam int AES_WORD_W          = 32;
  localparam int AES_WORDS_PER_BLOCK = 4;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [AES_WORD_W-1:0]  aes_word_t;

  typedef enum logic {
    IDLE,
    STREAM
  } aes_ser_state_t;

  // Word 0 is the most significant 32 bits of the block.
  function automatic aes_word_t aes_word_sel(input aes_block_t blk, input logic [1:0] idx);
    aes_word_t w;
    w = '0;
    case (idx)
      2'd0: w = blk[127:96];
      2'd1: w = blk[95:64];
      2'd2: w = blk[63:32];
      2'd3: w = blk[31:0];
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_block_fifo.sv
// DEPTH-entry FIFO of 128-bit plaintext blocks with count/full/empty status.
// Head entry is read combinationally so a freshly pushed block is visible next cycle.
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  aes_block_t               wr_data,
  output aes_block_t               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  aes_block_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;
  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);

endmodule

// File: rtl/aes_output_buffer.sv
// Buffers finished AES blocks and drains them as a 32-bit valid/ready word stream.
// Optional build macro AES_OUT_BSWAP_EN byte-reverses every output word.
module aes_output_buffer
  import aes_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     data_done,
  input  logic [127:0]             data_output,
  input  logic                     flush,
  output logic                     is_full,
  output logic [31:0]              word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     word_last,
  output logic [$clog2(DEPTH):0]   blocks_stored
);

  localparam int CW = $clog2(DEPTH) + 1;

  aes_ser_state_t  state_reg, state_next;
  logic [1:0]      k_reg, k_next;
  logic            push, pop, fire, empty;
  logic [CW-1:0]   count, count_next;
  aes_block_t      head;
  aes_word_t       slice, word_mux;

  assign push = data_done && !is_full && !flush;
  assign fire = word_valid && word_ready;
  assign pop  = fire && (k_reg == 2'd3) && !flush;
  assign count_next = count + CW'(push) - CW'(pop);

  aes_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (data_output),
    .rd_data (head),
    .count   (count),
    .full    (is_full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
    end
  end

  // Leaving IDLE on the push edge gives first-word latency of one cycle.
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    case (state_reg)
      IDLE: begin
        if (count_next != '0) state_next = STREAM;
      end
      STREAM: begin
        if (fire) begin
          if (k_reg == 2'd3) begin
            k_next = '0;
            if (count_next == '0) state_next = IDLE;
          end else begin
            k_next = k_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
      k_next     = '0;
    end
  end

  assign slice = aes_word_sel(head, k_reg);

`ifdef AES_OUT_BSWAP_EN
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_bswap
    assign word_mux[8*gi +: 8] = slice[31-8*gi -: 8];
  end
`else
  assign word_mux = slice;
`endif

  assign word_valid    = (state_reg == STREAM);
  assign word_last     = word_valid && (k_reg == 2'd3);
  assign word_out      = word_valid ? word_mux : '0;
  assign blocks_stored = count;

endmodule

// File: tb/tb_aes_output_buffer.sv
// Randomized self-checking bench for aes_output_buffer against a queue-based model.
// Honours AES_OUT_BSWAP_EN when the same macro is defined for the bench.
module tb_aes_output_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          data_done = 1'b0;
  logic [127:0]  data_output = '0;
  logic          flush = 1'b0;
  logic          word_ready = 1'b0;
  logic          is_full, word_valid, word_last;
  logic [31:0]   word_out;
  logic [CW-1:0] blocks_stored;

  aes_output_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .data_done     (data_done),
    .data_output   (data_output),
    .flush         (flush),
    .is_full       (is_full),
    .word_out      (word_out),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .word_last     (word_last),
    .blocks_stored (blocks_stored)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: a queue of stored blocks plus the index of the next word of the head.
  logic [127:0] mq[$];
  int           mk = 0;
  bit           accepted = 0;
  bit           m_push, m_fire;
  logic [127:0] m_head;

  function automatic logic [31:0] exp_word(input logic [127:0] b, input int k);
    logic [31:0] w;
    w = b[127-32*k -: 32];
`ifdef AES_OUT_BSWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mq.delete();
      mk = 0;
      accepted = 0;
    end else begin
      m_push = data_done && (mq.size() < DEPTH) && !flush;
      m_fire = (mq.size() > 0) && word_ready && !flush;
      accepted = m_push;
      if (flush) begin
        mq.delete();
        mk = 0;
      end else begin
        if (m_fire) begin
          m_head = mq[0];
          $display("word %h k=%0d last=%0d", exp_word(m_head, mk), mk, mk == 3);
          if (mk == 3) begin
            void'(mq.pop_front());
            mk = 0;
          end else begin
            mk++;
          end
        end
        if (m_push) mq.push_back(data_output);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cmp_all();
    bit           v;
    logic [127:0] h;
    logic [31:0]  w;
    v = (mq.size() > 0);
    h = v ? mq[0] : '0;
    w = v ? exp_word(h, mk) : 32'h0;
    chk("word_valid", word_valid, v);
    chk("word_out", word_out, w);
    chk("word_last", word_last, v && (mk == 3));
    chk("is_full", is_full, mq.size() == DEPTH);
    chk("blocks_stored", blocks_stored, mq.size());
  endtask

  task automatic step();
    @(negedge clk);
    cmp_all();
  endtask

  logic [31:0]  lit[4];
  logic [127:0] blk;

  initial begin
`ifdef AES_OUT_BSWAP_EN
    lit[0] = 32'h33221100; lit[1] = 32'h77665544; lit[2] = 32'hBBAA9988; lit[3] = 32'hFFEEDDCC;
`else
    lit[0] = 32'h00112233; lit[1] = 32'h44556677; lit[2] = 32'h8899AABB; lit[3] = 32'hCCDDEEFF;
`endif
    // Reset values
    repeat (2) step();
    chk("rst word_valid", word_valid, 1'b0);
    chk("rst word_out", word_out, 32'h0);
    chk("rst is_full", is_full, 1'b0);
    chk("rst blocks_stored", blocks_stored, 0);
    n_rst = 1'b1;
    step();

    // Single block, consumer always ready
    data_output = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    data_done = 1'b1;
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      data_done = 1'b0;
      chk("lit word", word_out, lit[i]);
      chk("lit valid", word_valid, 1'b1);
      chk("lit last", word_last, i == 3);
    end
    step();
    chk("lit valid after", word_valid, 1'b0);

    // Fill to full with consumer stalled
    word_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      data_output = {$urandom, $urandom, $urandom, $urandom};
      data_done = 1'b1;
      step();
    end
    chk("full lit", is_full, 1'b1);
    chk("full stored lit", blocks_stored, DEPTH);
    data_output = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) step();
    chk("5th held stored", blocks_stored, DEPTH);
    word_ready = 1'b1;
    repeat (3) step();
    chk("still full", is_full, 1'b1);
    step();
    chk("full drop", is_full, 1'b0);
    chk("stored after pop", blocks_stored, DEPTH - 1);
    step();
    chk("5th captured", accepted, 1'b1);
    chk("stored after 5th", blocks_stored, DEPTH);
    data_done = 1'b0;
    for (int i = 0; i < 40 && mq.size() > 0; i++) step();
    chk("drained", word_valid, 1'b0);

    // Flush mid-block
    word_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_output = {$urandom, $urandom, $urandom, $urandom};
      data_done = 1'b1;
      step();
    end
    data_done = 1'b0;
    word_ready = 1'b1;
    repeat (2) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush valid", word_valid, 1'b0);
    chk("flush stored", blocks_stored, 0);
    chk("flush full", is_full, 1'b0);
    blk = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    data_output = blk;
    data_done = 1'b1;
    step();
    data_done = 1'b0;
    chk("post flush word0", word_out, exp_word(blk, 0));
    repeat (4) step();

    // Randomized traffic with a core that holds each block until captured
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
      end
      if (!data_done || accepted) begin
        data_done = ($urandom_range(0, 9) < 6);
        data_output = {$urandom, $urandom, $urandom, $urandom};
      end
      word_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 99) < 2);
      step();
    end
    flush = 1'b0;
    data_done = 1'b0;
    word_ready = 1'b1;
    for (int i = 0; i < 40 && mq.size() > 0; i++) step();
    chk("final drain", mq.size(), 0);
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
